regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised multi-port register file for the BabySoC datapath. It replaces the fixed 4×4-bit, two-read/one-write register file with configurable width and depth. It adds three features: a write-to-read bypass, an optional hardwired-zero register 0, and a sequential clear engine that zeroes the array on request. It sits between instruction decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 4, data width in bits
- ADDR_W, 2, address width; depth is fixed at 2**ADDR_W entries
- ZERO_REG, 0, when 1, entry 0 always reads 0 and writes to it are discarded
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read port

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_data2  out  DATA_W  read port 2 data, combinational
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_blocked  out  1  high when wr_en is asserted while the clear engine is busy (write dropped)
- clr_req  in  1  request to zero all entries
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse after the last entry is cleared

## Operation
- Reset (asynchronous): all entries are 0; the FSM goes to IDLE; clear pointer is 0; clr_busy=0 and clr_done=0.
- Write commit:
  - At a rising edge with wr_en=1 and FSM in IDLE, wr_data is stored at wr_addr.
  - With ZERO_REG=1 and wr_addr=0, the write is discarded.
- Read, per port, evaluated in this priority order:
  1. ZERO_REG=1 and address 0 → 0.
  2. BYPASS=1, wr_en=1, FSM in IDLE, and wr_addr equals the read address → wr_data.
  3. Otherwise → the stored entry.
- Both read ports are independent; identical addresses return identical data.
- Clear FSM states:
  - IDLE → CLEAR on clr_req=1. Pointer is loaded with 0.
  - CLEAR: each cycle, entry[ptr] is written to 0 and ptr increments. When ptr=2**ADDR_W−1, the FSM goes to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- clr_busy=1 in CLEAR.
- clr_done is registered and equals 1 exactly while in DONE.
- clr_req is ignored in CLEAR and DONE. It is not queued; it must be re-asserted in IDLE.
- wr_en during CLEAR or DONE: the write is dropped and wr_blocked = wr_en & (FSM≠IDLE), combinationally. No bypass occurs in these states.
- Reads during CLEAR return stored contents. Entries already swept read 0.

## Timing
- Write-to-read latency:
  - 0 cycles with BYPASS=1, via the combinational forward.
  - 1 edge with BYPASS=0: the value is visible after the committing edge.
- Clear duration: clr_busy is high for exactly 2**ADDR_W cycles starting the edge after clr_req is sampled. clr_done is high for the following single cycle. Total clr_req-to-IDLE is 2**ADDR_W+1 edges.
- clr_req and wr_en together in IDLE: the write commits at that edge, CLEAR starts at the same edge, and the sweep zeroes that entry later. Final state is all-zero.
- The clear pointer is ADDR_W bits and wraps naturally. Termination is by the DONE transition, not by overflow.
- Reset asserted mid-clear: the array is zeroed immediately and the FSM returns to IDLE with clr_busy=0. No clr_done pulse occurs.
- Reset deassertion is synchronised externally. The first write is honoured at the first rising edge after deassertion.

## Test plan
- Reset then read: assert reset, then write 0xA to entry 1 and 0x5 to entry 3 → rd_addr1=1 gives 0xA and rd_addr2=3 gives 0x5. Reading all 4 addresses before the writes gives 0.
- Bypass: BYPASS=1, entry 2 holds 0x3, drive wr_en=1, wr_addr=2, wr_data=0xC with rd_addr1=2 → rd_data1=0xC in the same cycle. With BYPASS=0 → 0x3 that cycle, 0xC after the edge.
- Zero register: ZERO_REG=1, write 0xF to entry 0 → rd_data1 with rd_addr1=0 stays 0, including the bypass cycle.
- Clear sweep: fill entries with 0x1, 0x2, 0x3, 0x4, pulse clr_req → clr_busy high 4 cycles, clr_done high 1 cycle, then all reads 0. wr_en asserted during busy gives wr_blocked=1 and the write is lost.
- Simultaneous write and clr_req in IDLE: write 0x9 to entry 1 → entry 1 reads 0x9 after the edge and 0 after clr_done.
- Reset mid-clear: assert reset on the 2nd busy cycle → clr_busy=0 immediately, no clr_done, all entries read 0.

Source files
------------

// File: rtl/regfile_bypass.sv
// Parametrised 2-read/1-write register file with write-to-read forwarding,
// optional hardwired-zero entry 0 and a sequential clear engine.
module regfile_bypass #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_blocked,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             ptr;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic                          wr_live;
  logic                          wr_keep;

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  // Writes only land while the clear engine is parked.
  assign wr_live    = wr_en & (state == IDLE);
  assign wr_blocked = wr_en & (state != IDLE);
  assign wr_keep    = wr_live & ~((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem      <= '0;
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_keep) mem[wr_addr] <= wr_data;
          if (clr_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + 1'b1;
          if (&ptr) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Zero register wins over forwarding, forwarding wins over the array.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    d = mem[addr];
    if ((BYPASS != 0) && wr_live && (wr_addr == addr)) d = wr_data;
    if ((ZERO_REG != 0) && (addr == '0)) d = '0;
    return d;
  endfunction

  assign raddr = {rd_addr2, rd_addr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rdata[p] = rd_port(raddr[p]);
  end

  assign rd_data1 = rdata[0];
  assign rd_data2 = rdata[1];

endmodule

// File: tb/tb_regfile_bypass.sv
// Randomised plus directed bench for regfile_bypass: two instances
// (forwarding, no zero reg / zero reg, no forwarding) share one stimulus.
module tb_regfile_bypass;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] rd_addr1, rd_addr2, wr_addr;
  logic [3:0] wr_data;
  logic       wr_en, clr_req;

  logic [3:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic       a_blk, a_busy, a_done, b_blk, b_busy, b_done;

  regfile_bypass #(.DATA_W(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd1), .rd_data2(a_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_blocked(a_blk), .clr_req(clr_req),
    .clr_busy(a_busy), .clr_done(a_done));

  regfile_bypass #(.DATA_W(4), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_blocked(b_blk), .clr_req(clr_req),
    .clr_busy(b_busy), .clr_done(b_done));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: array contents plus "cycles of sweeping left" and a done flag.
  logic [3:0] ma [4];
  logic [3:0] mb [4];
  int         busy_left;
  bit         done_q;

  function automatic bit idle_m();
    return (busy_left == 0) && !done_q;
  endfunction

  function automatic logic [3:0] exp_rd(input bit is_b, input logic [1:0] a);
    if (is_b && a == 2'd0) return 4'h0;
    if (!is_b && wr_en && idle_m() && wr_addr == a) return wr_data;
    return is_b ? mb[a] : ma[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ma[i] = 4'h0;
      mb[i] = 4'h0;
    end
    busy_left = 0;
    done_q    = 1'b0;
  endtask

  task automatic model_edge();
    if (idle_m()) begin
      if (wr_en) begin
        ma[wr_addr] = wr_data;
        if (wr_addr != 2'd0) mb[wr_addr] = wr_data;
      end
      if (clr_req) busy_left = 4;
    end else if (busy_left > 0) begin
      ma[4 - busy_left] = 4'h0;
      mb[4 - busy_left] = 4'h0;
      busy_left--;
      if (busy_left == 0) done_q = 1'b1;
    end else begin
      done_q = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit exp_blk;
    exp_blk = wr_en && !idle_m();
    chk("a_rd1", a_rd1, exp_rd(1'b0, rd_addr1));
    chk("a_rd2", a_rd2, exp_rd(1'b0, rd_addr2));
    chk("b_rd1", b_rd1, exp_rd(1'b1, rd_addr1));
    chk("b_rd2", b_rd2, exp_rd(1'b1, rd_addr2));
    chk("a_busy", a_busy, busy_left > 0);
    chk("b_busy", b_busy, busy_left > 0);
    chk("a_done", a_done, done_q);
    chk("b_done", b_done, done_q);
    chk("a_blk", a_blk, exp_blk);
    chk("b_blk", b_blk, exp_blk);
  endtask

  // Inputs are set at the falling edge; checks happen 1 time unit later.
  task automatic drive(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                       input logic cr, input logic [1:0] r1, input logic [1:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd; clr_req = cr;
    rd_addr1 = r1; rd_addr2 = r2;
    #1;
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 2'(i), 2'(3 - i));
      chk("rst_rd", a_rd1, 4'h0);
      check_outputs();
    end
    reset = 1'b0;

    // Basic write then read
    drive(1, 1, 4'hA, 0, 0, 0); step();
    drive(1, 3, 4'h5, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 3);
    chk("rd_e1", a_rd1, 4'hA);
    chk("rd_e3", a_rd2, 4'h5);
    step();

    // Forwarding versus one-edge latency
    drive(1, 2, 4'h3, 0, 0, 0); step();
    drive(1, 2, 4'hC, 0, 2, 2);
    chk("byp_fwd", a_rd1, 4'hC);
    chk("nobyp_old", b_rd1, 4'h3);
    step();
    drive(0, 0, 0, 0, 2, 2);
    chk("nobyp_new", b_rd1, 4'hC);
    step();

    // Hardwired zero, including the write cycle
    drive(1, 0, 4'hF, 0, 0, 0);
    chk("zr_wr", b_rd1, 4'h0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("zr_after", b_rd1, 4'h0);
    chk("nzr_after", a_rd1, 4'hF);
    step();

    // Clear sweep with blocked writes
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 4'(i + 1), 0, 0, 0); step();
    end
    drive(0, 0, 0, 1, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 4'hE, 0, 2'(i), 2'(3 - i));
      chk("sweep_busy", a_busy, 1'b1);
      chk("sweep_blk", a_blk, 1'b1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("sweep_done", a_done, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 2'(i), 2'(i));
      chk("swept_rd", a_rd1, 4'h0);
      step();
    end

    // Write and clear request in the same cycle
    drive(1, 1, 4'h9, 1, 1, 1); step();
    drive(0, 0, 0, 0, 1, 1);
    chk("sim_wr", a_rd1, 4'h9);
    step();
    repeat (4) step();
    chk("sim_clr", a_rd1, 4'h0);
    step();

    // Reset in the second busy cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 4'(8 + i), 0, 0, 0); step();
    end
    drive(0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 1, 2); step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 2'(i), 2'(i));
      chk("rst_mid_rd", a_rd1, 4'h0);
      step();
    end

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
            $urandom_range(0, 11) == 0, 2'($urandom), 2'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
